sweep_scheduler: RTL and testbench
==================================

Name: sweep_scheduler

Overview:
- Sequences Mossbauer velocity-sweep binning from the rising/falling direction flags of the drive-signal edge detector.
- Debounces the direction, detects turnarounds and measures the half-sweep length.
- Slices each half-sweep into N_CHANNELS equal time bins. Emits the current spectrum channel plus a per-bin strobe to the histogram/counting datapath.
- Single clock domain (slow_clk), same domain as the direction detector.

Parameters:
- N_CHANNELS, 512, bins per half-sweep; power of two; total channels 2*N_CHANNELS.
- CH_WIDTH, 10, channel output width = log2(2*N_CHANNELS).
- PERIOD_WIDTH, 24, half-period counter width.
- DEBOUNCE, 4, consecutive cycles a direction must hold before acceptance.
- MIN_HALF, 1024, minimum legal half-period in cycles.

Ports:
- slow_clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run request; level.
- rising  in  1  direction flag, 1 = signal increasing.
- falling  in  1  direction flag, 1 = signal decreasing.
- channel  out  CH_WIDTH  current bin; rise half 0..N-1, fall half N..2N-1.
- ch_valid  out  1  one-cycle strobe when channel takes a new value.
- locked  out  1  high in RUN.
- half_period  out  PERIOD_WIDTH  last measured half-sweep length in cycles.
- sweep_cnt  out  32  completed full sweeps since leaving IDLE.
- err  out  1  sticky fault; cleared only by reset or enable low.

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator, index and counters 0.
- Direction debounce: raw dir = RISE when rising&!falling, FALL when falling&!rising; other combinations hold the previous dir. Accepted dir changes after DEBOUNCE consecutive cycles of the new raw value. A turnaround event is a one-cycle pulse on accepted change.
- States:
  - IDLE: enable=0; outputs frozen at 0 except err, which clears here. On enable=1 go to SEEK.
  - SEEK: wait for the first turnaround, then clear the period counter and go to MEASURE.
  - MEASURE: count cycles until the next turnaround. Count >= MIN_HALF: latch half_period, go to RUN. Otherwise: set err, return to SEEK.
  - RUN: locked=1; bin generation (below). Each turnaround latches the elapsed count into half_period. A count < MIN_HALF sets err and returns to SEEK.
- Any state with enable=0 goes to IDLE next cycle, including mid-bin; locked drops the same cycle.
- Bin generation (RUN): per cycle acc += N_CHANNELS. When acc >= half_period: acc -= half_period and idx++. idx saturates at N_CHANNELS-1; no wrap.
- Accumulator width: PERIOD_WIDTH+1, unsigned.
- At turnaround: acc=0, idx=0, phase toggles. sweep_cnt increments on entering the rise phase (wraps at 2^32).
- channel = phase ? N_CHANNELS+idx : idx.
- Output timing: channel registered, updated the cycle after the advance/turnaround decision. ch_valid asserts that same cycle. A turnaround and an advance in the same cycle resolve as the turnaround.
- Period counter saturates at all-ones. Saturation sets err and returns to SEEK.

Optional Feature:
- SWEEP_SCHEDULER_TIMEOUT_EN defined:
  - In RUN, if no turnaround occurs within 2*half_period cycles of the last one: err=1, locked=0, go to SEEK.
  - Watchdog restarts on each turnaround.
- Undefined: no watchdog; only counter saturation detects a lost sweep.

Decomposition:
- Shared package: state enum (IDLE, SEEK, MEASURE, RUN), direction encoding (RISE=0, FALL=1), default CH_WIDTH/PERIOD_WIDTH constants.
- One sub-module: dir_debounce. Owns the raw-direction decode, DEBOUNCE counter and turnaround pulse.
- Scheduler FSM, accumulator and counters stay in the top module.

Test Plan:
Bench parameters: N_CHANNELS=8, DEBOUNCE=2, MIN_HALF=16.
1. enable=1; triangle with 80-cycle rise / 80-cycle fall -> SEEK, then MEASURE latches half_period=80; locked=1; channel steps 0..7 every 10 cycles, then 8..15; 8 ch_valid per half; sweep_cnt increments each rise start.
2. Single-cycle glitch on falling during a rise -> no turnaround, channel progression unchanged.
3. Half-sweep of 10 cycles while in RUN -> err=1, locked=0, state SEEK; err holds until enable=0.
4. Rise stretched to 120 cycles after locking at 80 -> idx saturates at 7 (channel=7) until the turnaround; next half_period=120; fall bins every 15 cycles.
5. enable dropped mid-rise at channel=3 -> next cycle locked=0, channel=0, ch_valid=0, err=0; re-enable restarts from SEEK.
6. With SWEEP_SCHEDULER_TIMEOUT_EN: lock at 80, then hold rising constant for 200 cycles -> err=1 at cycle 160 after the last turnaround, state SEEK. Without the macro -> no err until counter saturation.

Source files
------------

// File: rtl/sweep_scheduler_pkg.sv
// sweep_scheduler_pkg: shared state/direction encodings and default widths for the sweep scheduler
package sweep_scheduler_pkg;
   typedef enum logic [1:0] {IDLE, SEEK, MEASURE, RUN} state_t;
   typedef enum logic {RISE = 1'b0, FALL = 1'b1} dir_t;
   localparam int DEF_CH_WIDTH = 10;
   localparam int DEF_PERIOD_WIDTH = 24;
endpackage

// File: rtl/sweep_scheduler_if.sv
// sweep_scheduler_if: run/direction inputs and channel/status outputs of the sweep scheduler
interface sweep_scheduler_if #(
   parameter int CH_WIDTH = sweep_scheduler_pkg::DEF_CH_WIDTH,
   parameter int PERIOD_WIDTH = sweep_scheduler_pkg::DEF_PERIOD_WIDTH
);
   logic enable;
   logic rising;
   logic falling;
   logic [CH_WIDTH-1:0] channel;
   logic ch_valid;
   logic locked;
   logic [PERIOD_WIDTH-1:0] half_period;
   logic [31:0] sweep_cnt;
   logic err;
   modport master (output enable, rising, falling, input channel, ch_valid, locked, half_period, sweep_cnt, err);
   modport slave (input enable, rising, falling, output channel, ch_valid, locked, half_period, sweep_cnt, err);
endinterface

// File: rtl/sweep_scheduler_dir_debounce.sv
// sweep_scheduler_dir_debounce: decodes raw direction, debounces it and pulses on each accepted turnaround
module sweep_scheduler_dir_debounce import sweep_scheduler_pkg::*; #(
   parameter int DEBOUNCE = 4
) (
   input  logic slow_clk,
   input  logic rst,
   input  logic rising,
   input  logic falling,
   output dir_t dir,
   output logic turn
);
   localparam int CW = $clog2(DEBOUNCE) + 1;
   dir_t raw, raw_q;
   logic [CW-1:0] cnt;
   // ambiguous flag combinations keep the last raw direction
   always_comb raw = (rising & ~falling) ? RISE : (falling & ~rising) ? FALL : raw_q;
   // accept a new direction after DEBOUNCE consecutive cycles of it, pulsing turn once
   always_ff @(posedge slow_clk or negedge rst)
      if (!rst) begin
         raw_q <= RISE;
         dir <= RISE;
         cnt <= '0;
         turn <= 1'b0;
      end else begin
         raw_q <= raw;
         turn <= 1'b0;
         if (raw == dir) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE - 1)) begin
            dir <= raw;
            cnt <= '0;
            turn <= 1'b1;
         end else cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/sweep_scheduler.sv
// sweep_scheduler: locks onto the drive sweep and slices each half into N_CHANNELS time bins; SWEEP_SCHEDULER_TIMEOUT_EN adds a lost-sweep watchdog
module sweep_scheduler import sweep_scheduler_pkg::*; #(
   parameter int N_CHANNELS = 512,
   parameter int CH_WIDTH = DEF_CH_WIDTH,
   parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
   parameter int DEBOUNCE = 4,
   parameter int MIN_HALF = 1024
) (
   input logic slow_clk,
   input logic rst,
   sweep_scheduler_if.slave bus
);
   localparam int IW = $clog2(N_CHANNELS);
   localparam int PW1 = PERIOD_WIDTH + 1;
   localparam logic [PERIOD_WIDTH:0] MIN_W = PW1'(MIN_HALF);
   localparam logic [PERIOD_WIDTH:0] N_W = PW1'(N_CHANNELS);
   state_t state, state_n;
   dir_t dir, phase, phase_n;
   logic turn, sat, wd, adv, err, err_n, valid, valid_n;
   logic [PERIOD_WIDTH:0] acc, acc_n, sum, elapsed;
   logic [IW-1:0] idx, idx_n;
   logic [PERIOD_WIDTH-1:0] cnt, cnt_n, hp, hp_n;
   logic [31:0] sweep, sweep_n;
   logic [CH_WIDTH-1:0] channel, ch_n;
   sweep_scheduler_dir_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .slow_clk(slow_clk),
      .rst(rst),
      .rising(bus.rising),
      .falling(bus.falling),
      .dir(dir),
      .turn(turn)
   );
   assign sum = acc + N_W;
   assign adv = sum >= {1'b0, hp};
   assign elapsed = {1'b0, cnt} + 1'b1;
   assign sat = &cnt;
`ifdef SWEEP_SCHEDULER_TIMEOUT_EN
   assign wd = elapsed >= {hp, 1'b0};
`else
   assign wd = 1'b0;
`endif
   // next-state: lock sequencing, period measurement, bin advance and fault handling
   always_comb begin
      state_n = state;
      acc_n = acc;
      idx_n = idx;
      phase_n = phase;
      cnt_n = sat ? cnt : cnt + 1'b1;
      hp_n = hp;
      sweep_n = sweep;
      err_n = err;
      valid_n = 1'b0;
      case (state)
         IDLE: state_n = SEEK;
         SEEK: begin
            cnt_n = '0;
            state_n = turn ? MEASURE : SEEK;
         end
         MEASURE, RUN: begin
            if (sat || (turn && elapsed < MIN_W) || (state == RUN && wd && !turn)) begin
               err_n = 1'b1;
               state_n = SEEK;
            end else if (turn) begin
               state_n = RUN;
               cnt_n = '0;
               hp_n = elapsed[PERIOD_WIDTH-1:0];
               acc_n = '0;
               idx_n = '0;
               phase_n = dir;
               valid_n = 1'b1;
               if (state == RUN && dir == RISE) sweep_n = sweep + 1'b1;
            end else if (state == RUN) begin
               acc_n = adv ? sum - {1'b0, hp} : sum;
               idx_n = (adv && !(&idx)) ? idx + 1'b1 : idx;
               valid_n = adv && !(&idx);
            end
         end
         default: state_n = IDLE;
      endcase
      if (!bus.enable) begin
         state_n = IDLE;
         acc_n = '0;
         idx_n = '0;
         phase_n = RISE;
         cnt_n = '0;
         hp_n = '0;
         sweep_n = '0;
         err_n = 1'b0;
         valid_n = 1'b0;
      end
      ch_n = (state_n == RUN) ? CH_WIDTH'({phase_n, idx_n}) : '0;
   end
   // state and datapath registers
   always_ff @(posedge slow_clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         acc <= '0;
         idx <= '0;
         phase <= RISE;
         cnt <= '0;
         hp <= '0;
         sweep <= '0;
         err <= 1'b0;
         valid <= 1'b0;
         channel <= '0;
      end else begin
         state <= state_n;
         acc <= acc_n;
         idx <= idx_n;
         phase <= phase_n;
         cnt <= cnt_n;
         hp <= hp_n;
         sweep <= sweep_n;
         err <= err_n;
         valid <= valid_n;
         channel <= ch_n;
      end
   assign bus.channel = channel;
   assign bus.ch_valid = valid;
   assign bus.locked = state == RUN;
   assign bus.half_period = hp;
   assign bus.sweep_cnt = sweep;
   assign bus.err = err;
endmodule

// File: tb/tb_sweep_scheduler.sv
// tb_sweep_scheduler: directed and randomized sweeps checked against a bin-arithmetic reference model
module tb_sweep_scheduler;
   localparam int N = 8;
   localparam int DB = 2;
   localparam int MINH = 16;
`ifdef SWEEP_SCHEDULER_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif
   logic slow_clk = 1'b0;
   logic rst;
   int total = 0;
   int bad = 0;
   int n_edge = 0;
   int vcount = 0;
   int raw_prev = 0, acc_dir = 0, pend_dir = 0;
   bit pend_turn = 0;
   int hist[$];
   int m_mode = 0, m_err = 0, m_hp = 0, m_sweep = 0, m_chan = 0, m_valid = 0;
   int m_phase = 0, m_start = 0, m_idx = 0, t_last = 0;
   always #5 slow_clk = ~slow_clk;
   sweep_scheduler_if #(.CH_WIDTH(4), .PERIOD_WIDTH(24)) bus ();
   sweep_scheduler #(.N_CHANNELS(N), .CH_WIDTH(4), .PERIOD_WIDTH(24), .DEBOUNCE(DB), .MIN_HALF(MINH)) dut (
      .slow_clk(slow_clk),
      .rst(rst),
      .bus(bus.slave)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, n_edge);
      end
   endtask
   // reference: debounce as a window of the last DB raw directions, bins as floor(k*N/half_period)
   task automatic model_edge(input logic en, input logic r, input logic f);
      int raw, el, k, i0, i1, tdir;
      bit turn_now, trig;
      n_edge++;
      turn_now = pend_turn;
      tdir = pend_dir;
      raw = (r && !f) ? 0 : (f && !r) ? 1 : raw_prev;
      raw_prev = raw;
      hist.push_back(raw);
      if (hist.size() > DB) void'(hist.pop_front());
      trig = (hist.size() == DB) && (raw != acc_dir);
      foreach (hist[i]) if (hist[i] != raw) trig = 0;
      pend_turn = trig;
      if (trig) begin
         acc_dir = raw;
         pend_dir = raw;
      end
      m_valid = 0;
      if (!en) begin
         m_mode = 0; m_err = 0; m_hp = 0; m_sweep = 0;
      end else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
         if (turn_now) begin m_mode = 2; t_last = n_edge; end
      end else if (turn_now) begin
         el = n_edge - t_last;
         t_last = n_edge;
         if (el < MINH) begin
            m_err = 1; m_mode = 1;
         end else begin
            if (m_mode == 3 && tdir == 0) m_sweep++;
            m_mode = 3; m_hp = el; m_phase = tdir; m_start = n_edge; m_idx = 0; m_valid = 1;
         end
      end else if (m_mode == 3) begin
         if (TMO && (n_edge - t_last >= 2 * m_hp)) begin
            m_err = 1; m_mode = 1;
         end else begin
            k = n_edge - m_start;
            i1 = (k * N / m_hp > N - 1) ? N - 1 : k * N / m_hp;
            i0 = ((k - 1) * N / m_hp > N - 1) ? N - 1 : (k - 1) * N / m_hp;
            m_idx = i1;
            m_valid = int'(i1 != i0);
         end
      end
      m_chan = (m_mode == 3) ? m_phase * N + m_idx : 0;
   endtask
   task automatic step(input logic en, input logic r, input logic f);
      bus.enable = en;
      bus.rising = r;
      bus.falling = f;
      @(posedge slow_clk);
      model_edge(en, r, f);
      @(negedge slow_clk);
      if (bus.ch_valid === 1'b1) vcount++;
      chk("channel", bus.channel, m_chan);
      chk("ch_valid", bus.ch_valid, m_valid);
      chk("locked", bus.locked, m_mode == 3);
      chk("err", bus.err, m_err);
      chk("half_period", bus.half_period, m_hp);
      chk("sweep_cnt", bus.sweep_cnt, m_sweep);
   endtask
   task automatic seg(input int d, input int len, input int glitch_at, input bit noisy);
      for (int i = 0; i < len; i++) begin
         logic r, f;
         r = (d == 0);
         f = (d == 1);
         if (i == glitch_at) begin r = ~r; f = ~f; end
         if (noisy && $urandom_range(0, 7) == 0) begin
            r = 1'($urandom_range(0, 1));
            f = r;
         end
         step(1'b1, r, f);
      end
   endtask
   initial begin
      int len;
      rst = 1'b0;
      bus.enable = 1'b0;
      bus.rising = 1'b0;
      bus.falling = 1'b0;
      repeat (3) @(negedge slow_clk);
      chk("rst_channel", bus.channel, 0);
      chk("rst_ch_valid", bus.ch_valid, 0);
      chk("rst_locked", bus.locked, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_half_period", bus.half_period, 0);
      chk("rst_sweep_cnt", bus.sweep_cnt, 0);
      rst = 1'b1;
      seg(0, 30, -1, 0);
      seg(1, 80, -1, 0);
      seg(0, 80, -1, 0);
      chk("lock_half_period", bus.half_period, 80);
      chk("lock_locked", bus.locked, 1);
      vcount = 0;
      seg(1, 80, -1, 0);
      chk("valids_per_half", vcount, 8);
      seg(0, 80, -1, 0);
      chk("sweep_after_first_rise", bus.sweep_cnt, 1);
      seg(1, 80, -1, 0);
      seg(0, 80, 40, 0);
      chk("sweep_after_glitch", bus.sweep_cnt, 2);
      seg(1, 80, -1, 0);
      seg(0, 120, -1, 0);
      chk("stretch_saturated", bus.channel, 7);
      seg(1, 80, -1, 0);
      chk("stretch_half_period", bus.half_period, 120);
      for (int i = 0; i < 6; i++) begin
         len = int'($urandom_range(20, 150));
         seg(i % 2, len, int'($urandom_range(0, len + 10)), 1);
      end
      seg(0, 80, -1, 0);
      seg(1, 10, -1, 0);
      seg(0, 5, -1, 0);
      chk("short_err", bus.err, 1);
      chk("short_unlocked", bus.locked, 0);
      seg(0, 75, -1, 0);
      seg(1, 80, -1, 0);
      seg(0, 80, -1, 0);
      seg(1, 80, -1, 0);
      chk("err_sticky", bus.err, 1);
      chk("relocked", bus.locked, 1);
      seg(0, 35, -1, 0);
      chk("mid_rise_channel", bus.channel, 3);
      step(1'b0, 1'b1, 1'b0);
      chk("dis_locked", bus.locked, 0);
      chk("dis_channel", bus.channel, 0);
      chk("dis_err", bus.err, 0);
      repeat (4) step(1'b0, 1'b1, 1'b0);
      seg(0, 40, -1, 0);
      seg(1, 80, -1, 0);
      seg(0, 80, -1, 0);
      chk("reenable_locked", bus.locked, 1);
      chk("reenable_half_period", bus.half_period, 80);
      seg(1, 80, -1, 0);
      seg(0, 200, -1, 0);
      chk("hold_err", bus.err, TMO ? 1 : 0);
      chk("hold_locked", bus.locked, TMO ? 0 : 1);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
